// File: rtl/rv32im_pkg.sv
// Shared RV32IM constants: datapath width, ALU opcode encoding (matches the
// ALU), ID_CTRL bit positions and the operand forwarding select encoding.
package rv32im_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned OPC_W      = 5;
  localparam int unsigned CTRL_W     = 7;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  // ID_CTRL = {OP1_PC, OP2_IMM, REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, JUMP}
  localparam int unsigned CTRL_JUMP      = 0;
  localparam int unsigned CTRL_BRANCH    = 1;
  localparam int unsigned CTRL_MEM_WRITE = 2;
  localparam int unsigned CTRL_MEM_READ  = 3;
  localparam int unsigned CTRL_REG_WRITE = 4;
  localparam int unsigned CTRL_OP2_IMM   = 5;
  localparam int unsigned CTRL_OP1_PC    = 6;

  // Forwarding source select
  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_pipeline_reg_fwd_mux.sv
// Forwarding mux for one EX source operand: EX/MEM beats MEM/WB beats the
// registered value; x0 is never forwarded.
module fwd_mux #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [XLEN-1:0]       reg_val,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       value
);
  import rv32im_pkg::*;

  fwd_sel_e sel;

  // Pick the youngest in-flight producer of src, then steer its value
  always_comb begin
    sel = FWD_REG;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src))
      sel = FWD_EXMEM;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src))
      sel = FWD_MEMWB;

    unique case (sel)
      FWD_EXMEM: value = exmem_result;
      FWD_MEMWB: value = memwb_result;
      default:   value = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register feeding the RV32IM ALU: load-use bubble insertion,
// FLUSH/HOLD handling and EX/MEM + MEM/WB operand forwarding.
// Optional: define ID_EX_HAZARD_COUNTERS_EN to add BUBBLE_COUNT/FLUSH_COUNT.
module id_ex_pipeline_reg #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned OPC_W      = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [XLEN-1:0]       ID_PC,
  input  logic [XLEN-1:0]       ID_RS1_DATA,
  input  logic [XLEN-1:0]       ID_RS2_DATA,
  input  logic [XLEN-1:0]       ID_IMM,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic [OPC_W-1:0]      ID_ALU_OPCODE,
  input  logic [6:0]            ID_CTRL,
  input  logic                  ID_VALID,
  input  logic                  FLUSH,
  input  logic                  HOLD,
  input  logic [REG_ADDR_W-1:0] EXMEM_RD,
  input  logic                  EXMEM_REG_WRITE,
  input  logic [XLEN-1:0]       EXMEM_RESULT,
  input  logic [REG_ADDR_W-1:0] MEMWB_RD,
  input  logic                  MEMWB_REG_WRITE,
  input  logic [XLEN-1:0]       MEMWB_RESULT,
  output logic [XLEN-1:0]       DATA1,
  output logic [XLEN-1:0]       DATA2,
  output logic [OPC_W-1:0]      ALU_OPCODE,
  output logic [XLEN-1:0]       EX_RS2_FWD,
  output logic [XLEN-1:0]       EX_PC,
  output logic [XLEN-1:0]       EX_IMM,
  output logic [REG_ADDR_W-1:0] EX_RD,
  output logic [6:0]            EX_CTRL,
  output logic                  EX_VALID,
`ifdef ID_EX_HAZARD_COUNTERS_EN
  output logic [31:0]           BUBBLE_COUNT,
  output logic [31:0]           FLUSH_COUNT,
`endif
  output logic                  HAZARD_STALL
);
  import rv32im_pkg::*;

  logic [XLEN-1:0]       ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [OPC_W-1:0]      ex_opc_q;
  logic [6:0]            ex_ctrl_q;
  logic                  ex_valid_q;

  logic                  hazard_stall;
  logic                  load_bubble, load_id;
  logic                  memwb_hit_rs1, memwb_hit_rs2;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;

  // Load-use detection and next-state selection (FLUSH > HOLD > stall > load)
  always_comb begin
    hazard_stall = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && ID_VALID &&
                   (ex_rd_q != '0) && ((ex_rd_q == ID_RS1) || (ex_rd_q == ID_RS2)) &&
                   !FLUSH;
    load_bubble  = FLUSH || (!HOLD && (hazard_stall || !ID_VALID));
    load_id      = !FLUSH && !HOLD && !hazard_stall && ID_VALID;
    memwb_hit_rs1 = MEMWB_REG_WRITE && (MEMWB_RD != '0) && (MEMWB_RD == ex_rs1_q);
    memwb_hit_rs2 = MEMWB_REG_WRITE && (MEMWB_RD != '0) && (MEMWB_RD == ex_rs2_q);
  end

  // Stage register; a held stage still absorbs MEM/WB writebacks to its sources
  always_ff @(posedge CLK) begin
    if (!RESET || load_bubble) begin
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_opc_q      <= OPC_W'(ALU_ADD);
      ex_ctrl_q     <= '0;
      ex_valid_q    <= 1'b0;
    end else if (load_id) begin
      ex_pc_q       <= ID_PC;
      ex_rs1_data_q <= ID_RS1_DATA;
      ex_rs2_data_q <= ID_RS2_DATA;
      ex_imm_q      <= ID_IMM;
      ex_rs1_q      <= ID_RS1;
      ex_rs2_q      <= ID_RS2;
      ex_rd_q       <= ID_RD;
      ex_opc_q      <= ID_ALU_OPCODE;
      ex_ctrl_q     <= ID_CTRL;
      ex_valid_q    <= 1'b1;
    end else begin
      if (memwb_hit_rs1) ex_rs1_data_q <= MEMWB_RESULT;
      if (memwb_hit_rs2) ex_rs2_data_q <= MEMWB_RESULT;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src(ex_rs1_q), .reg_val(ex_rs1_data_q),
    .exmem_rd(EXMEM_RD), .exmem_reg_write(EXMEM_REG_WRITE), .exmem_result(EXMEM_RESULT),
    .memwb_rd(MEMWB_RD), .memwb_reg_write(MEMWB_REG_WRITE), .memwb_result(MEMWB_RESULT),
    .value(fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src(ex_rs2_q), .reg_val(ex_rs2_data_q),
    .exmem_rd(EXMEM_RD), .exmem_reg_write(EXMEM_REG_WRITE), .exmem_result(EXMEM_RESULT),
    .memwb_rd(MEMWB_RD), .memwb_reg_write(MEMWB_REG_WRITE), .memwb_result(MEMWB_RESULT),
    .value(fwd_rs2)
  );

  // ALU operand selection and stage outputs
  always_comb begin
    DATA1        = ex_ctrl_q[CTRL_OP1_PC]  ? ex_pc_q  : fwd_rs1;
    DATA2        = ex_ctrl_q[CTRL_OP2_IMM] ? ex_imm_q : fwd_rs2;
    EX_RS2_FWD   = fwd_rs2;
    ALU_OPCODE   = ex_opc_q;
    EX_PC        = ex_pc_q;
    EX_IMM       = ex_imm_q;
    EX_RD        = ex_rd_q;
    EX_CTRL      = ex_ctrl_q;
    EX_VALID     = ex_valid_q;
    HAZARD_STALL = hazard_stall;
  end

`ifdef ID_EX_HAZARD_COUNTERS_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  // Saturating event counters; held cycles are not counted
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (FLUSH && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (!HOLD && hazard_stall && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  always_comb begin
    BUBBLE_COUNT = bubble_cnt_q;
    FLUSH_COUNT  = flush_cnt_q;
  end
`endif

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register directly upstream of the RV32IM ALU.
- Captures the decoded instruction bundle from ID each cycle.
- Detects load-use hazards and inserts bubbles.
- Applies EX/MEM and MEM/WB forwarding, then drives the ALU's DATA1, DATA2 and 5-bit ALU_OPCODE.
- Honours FLUSH from branch resolution and HOLD from downstream multi-cycle units.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- OPC_W, 5, ALU opcode width (same encoding as the ALU: ADD=0 … REMU=17).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- ID_PC  in  XLEN  PC of the ID instruction.
- ID_RS1_DATA, ID_RS2_DATA  in  XLEN  register-file read values.
- ID_IMM  in  XLEN  sign-extended immediate.
- ID_RS1, ID_RS2, ID_RD  in  REG_ADDR_W  register indices.
- ID_ALU_OPCODE  in  OPC_W  ALU operation.
- ID_CTRL  in  7  {OP1_PC, OP2_IMM, REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, JUMP}.
- ID_VALID  in  1  ID holds a real instruction.
- FLUSH  in  1  branch/jump taken in EX; kill ID/EX contents.
- HOLD  in  1  downstream busy; freeze this stage.
- EXMEM_RD  in  REG_ADDR_W, EXMEM_REG_WRITE  in  1, EXMEM_RESULT  in  XLEN  EX/MEM forwarding source.
- MEMWB_RD  in  REG_ADDR_W, MEMWB_REG_WRITE  in  1, MEMWB_RESULT  in  XLEN  MEM/WB forwarding source.
- DATA1  out  XLEN  ALU operand A.
- DATA2  out  XLEN  ALU operand B.
- ALU_OPCODE  out  OPC_W  to ALU.
- EX_RS2_FWD  out  XLEN  forwarded rs2, used as store data.
- EX_PC, EX_IMM  out  XLEN  for branch target.
- EX_RD  out  REG_ADDR_W.
- EX_CTRL  out  7.
- EX_VALID  out  1.
- HAZARD_STALL  out  1  to PC/IF/ID: hold, ID re-presents the same instruction.

Behaviour:
- Reset (RESET=0 at edge):
  - All registered fields become 0; EX_VALID=0; EX_CTRL=0; ALU_OPCODE=ADD (0).
  - DATA1/DATA2 therefore read 0 unless forwarding matches; with rd=0 they never match.
- Load-use hazard (combinational):
  - HAZARD_STALL = EX_VALID & EX_CTRL.MEM_READ & ID_VALID & (EX_RD≠0) & (EX_RD==ID_RS1 | EX_RD==ID_RS2) & ~FLUSH.
- Edge update priority: RESET > FLUSH > HOLD > HAZARD_STALL > load.
  - FLUSH: load bubble (EX_VALID=0, EX_CTRL=0, EX_RD=0, opcode ADD).
  - HOLD: all fields retain. While holding, a MEMWB match against the held rs1/rs2 overwrites the held source value, so no writeback is lost.
  - HAZARD_STALL: load bubble. Exactly one bubble per load-use pair.
  - Load: capture all ID_* fields; EX_VALID=ID_VALID. If ID_VALID=0, load a bubble.
- Forwarding (combinational on outputs) for src in {rs1, rs2}:
  - If EXMEM_REG_WRITE & EXMEM_RD≠0 & EXMEM_RD==src: use EXMEM_RESULT (highest priority).
  - Else if MEMWB_REG_WRITE & MEMWB_RD≠0 & MEMWB_RD==src: use MEMWB_RESULT.
  - Else use the registered value.
  - Register x0 is never forwarded.
- Operand selection:
  - DATA1 = OP1_PC ? EX_PC : fwd_rs1.
  - DATA2 = OP2_IMM ? EX_IMM : fwd_rs2.
  - EX_RS2_FWD = fwd_rs2 always.
- Latency: one cycle ID→EX; forwarding is zero-cycle.
- Simultaneous events:
  - FLUSH with HOLD: flush wins.
  - FLUSH with hazard: HAZARD_STALL is forced low and a bubble is loaded.
  - Reset mid-HOLD: clears state.

Optional Feature:
- Macro: ID_EX_HAZARD_COUNTERS_EN.
- When defined, adds outputs BUBBLE_COUNT (32) and FLUSH_COUNT (32).
  - Counters increment on edges where a load-use bubble or a flush is loaded, respectively.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
  - HOLD cycles do not count.
- When undefined: no counters and no extra ports; all other behaviour is identical.

Decomposition:
- Package rv32im_pkg holds:
  - ALU opcode constants (ADD..REMU, 5-bit).
  - ID_CTRL bit-position constants.
  - XLEN.
  - Forwarding-select encoding (FWD_REG=0, FWD_MEMWB=1, FWD_EXMEM=2).
- One sub-module, fwd_mux, is natural: it produces the forwarding select and value for one source and is instantiated for rs1 and rs2.

Test Plan:
- Reset: RESET=0 for 2 cycles with ID_VALID=1 → EX_VALID=0, ALU_OPCODE=0, EX_CTRL=0; release → next edge captures the ID bundle.
- Forwarding priority: EX has rs1=5; EXMEM_RD=5/REG_WRITE=1/RESULT=0x11; MEMWB_RD=5/RESULT=0x22 → DATA1=0x11. Drop EXMEM_REG_WRITE → DATA1=0x22. Set rs1=0 with both matching → registered value.
- Load-use: EX holds lw x7 (MEM_READ=1); ID holds add rs2=7 → HAZARD_STALL=1 for exactly one cycle, then one bubble (EX_VALID=0); the add enters the following cycle with DATA2 = MEMWB_RESULT once MEMWB_RD=7.
- FLUSH vs HOLD vs hazard: assert FLUSH, HOLD and the hazard condition together → HAZARD_STALL=0; next edge EX_VALID=0, EX_CTRL=0.
- HOLD with writeback: hold 3 cycles holding rs1=9; in cycle 2 MEMWB writes x9=0xDEAD → after HOLD drops, DATA1=0xDEAD with no EX/MEM match.
- Counters (macro defined): 3 load-use bubbles and 2 flushes → BUBBLE_COUNT=3, FLUSH_COUNT=2; preload near saturation → counter holds at 0xFFFFFFFF.
